free_list: RTL
==============

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter N, default 3, superscalar width (dispatch and retire slots per cycle).
REQ-002 SHALL have parameter PHYS_REG_SZ, default 64, number of physical registers.
REQ-003 SHALL have parameter ARCH_REG_SZ, default 32, number of architectural registers.
REQ-004 SHALL use derived widths: IDX_W = clog2(PHYS_REG_SZ); CNT_W = clog2(N+1).
REQ-005 SHALL have ports, listed as name, direction, width, meaning:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- num_dispatched  in  CNT_W  registers consumed by dispatch this cycle
- retire_valid  in  N  per-slot retire strobe
- retire_reg  in  N*IDX_W  per-slot told physical register being freed
- restore_valid  in  1  branch mispredict restore
- restore_free_list  in  PHYS_REG_SZ  checkpointed free vector from branch stack
- regs_to_use  out  N*IDX_W  lowest-index free registers offered to dispatch
- num_regs_available  out  CNT_W  min(free count, N)
- free_list_copy  out  PHYS_REG_SZ  current registered free vector
- updated_free_list  out  PHYS_REG_SZ  free vector after this cycle's dispatch, before retire
- double_free_error  out  1  sticky error flag

Function
REQ-006 SHALL hold state as a registered bit vector free_q[PHYS_REG_SZ-1:0]; 1 = free.
REQ-007 SHALL drive regs_to_use[i] combinationally as the index of the (i+1)-th lowest set bit of free_q; 0 when fewer than i+1 bits are set.
REQ-008 SHALL drive num_regs_available = min(popcount(free_q), N), combinational from free_q only.
REQ-009 SHALL clamp effective dispatch count: eff = min(num_dispatched, num_regs_available); eff = 0 when restore_valid.
REQ-010 SHALL drive updated_free_list = free_q with bits regs_to_use[0..eff-1] cleared, combinationally.
REQ-011 SHALL drive free_list_copy = free_q.
REQ-012 SHALL compute retire set R = OR over i with retire_valid[i] of onehot(retire_reg[i]); multiple slots naming the same register are legal and free it once.
REQ-013 SHALL update next cycle, when not restoring: free_q <= updated_free_list | R.
REQ-014 SHALL update next cycle, when restore_valid: free_q <= restore_free_list | R; num_dispatched ignored.
REQ-015 SHALL give 1-cycle free latency: a register retired in cycle t is never offered in cycle t; it is offered from t+1.
REQ-016 SHALL offer only registers set in free_q; a register retired and freshly allocated in the same cycle is never double-issued.
REQ-017 SHALL set double_free_error at t+1 when, in cycle t, any retire_valid[i] names a register already set in free_q; the flag holds until reset and does not block the free.
REQ-018 SHALL treat retire_reg values >= PHYS_REG_SZ as no-ops.
REQ-019 SHALL, when no register is free: num_regs_available = 0, all regs_to_use = 0, and dispatch has no effect.

Reset
REQ-020 SHALL on reset set free_q[j] = 1 for ARCH_REG_SZ <= j < PHYS_REG_SZ and 0 otherwise, with double_free_error = 0.
REQ-021 SHALL give reset priority over restore, dispatch and retire in the same cycle; reset applied mid-operation discards all pending updates.
REQ-022 SHALL, one cycle after reset at defaults: regs_to_use = {32,33,34}, num_regs_available = 3, free_list_copy = 64'hFFFFFFFF_00000000.

Verification
REQ-023 SHALL cover drain to empty: num_dispatched = 3 for 10 cycles -> regs_to_use = {62,63,0}, num_regs_available = 2; then num_dispatched = 2 -> num_regs_available = 0, free_q = 0.
REQ-024 SHALL cover same-cycle retire plus dispatch: from the drained state, retire 5 with num_dispatched = 3 -> that cycle num_regs_available = 0; next cycle regs_to_use[0] = 5, num_regs_available = 1.
REQ-025 SHALL cover restore: after reset, save C = free_list_copy, dispatch 3+3, then restore_valid with restore_free_list = C, num_dispatched = 3, retire 7 -> free_q = C | bit 7, regs_to_use = {7,32,33}.
REQ-026 SHALL cover overclaim: after reset, drain to 1 free, then num_dispatched = 3 -> only 1 register is cleared, free_q = 0.
REQ-027 SHALL cover double free: after reset, retire 40 -> double_free_error = 1 next cycle and held; free_q[40] stays 1; reset clears the flag.
REQ-028 SHALL cover duplicate retire: two slots retire 10 in one cycle -> free_q[10] = 1 and double_free_error stays 0.

Source files
------------

// File: rtl/free_list.sv
// Physical register free list: offers the N lowest free registers, clears those dispatched, frees retired ones.
// Latency: offers are combinational from free_q, and a retired register is offered from the next cycle. Backpressure: dispatch is clamped to num_regs_available.
module free_list #(
    parameter int N           = 3,
    parameter int PHYS_REG_SZ = 64,
    parameter int ARCH_REG_SZ = 32,
    parameter int IDX_W       = $clog2(PHYS_REG_SZ),
    parameter int CNT_W       = $clog2(N + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CNT_W-1:0]       num_dispatched,
    input  logic [N-1:0]           retire_valid,
    input  logic [N*IDX_W-1:0]     retire_reg,
    input  logic                   restore_valid,
    input  logic [PHYS_REG_SZ-1:0] restore_free_list,
    output logic [N*IDX_W-1:0]     regs_to_use,
    output logic [CNT_W-1:0]       num_regs_available,
    output logic [PHYS_REG_SZ-1:0] free_list_copy,
    output logic [PHYS_REG_SZ-1:0] updated_free_list,
    output logic                   double_free_error
);

    logic [PHYS_REG_SZ-1:0] free_q;
    logic [PHYS_REG_SZ-1:0] mask;
    logic [PHYS_REG_SZ-1:0] retire_set;
    logic [IDX_W:0]         pop;
    logic [CNT_W-1:0]       eff_cnt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       r;
    logic                   found;
    logic                   dbl_free;

    // Registers above the architectural range start free; the rest hold committed state.
    function automatic logic [PHYS_REG_SZ-1:0] reset_vec();
        logic [PHYS_REG_SZ-1:0] v;
        v = '0;
        for (int j = ARCH_REG_SZ; j < PHYS_REG_SZ; j++) begin
            v[j] = 1'b1;
        end
        return v;
    endfunction

    // Successive lowest-set-bit picks; each pick is masked out before the next.
    always_comb begin
        mask        = free_q;
        regs_to_use = '0;
        found       = 1'b0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            found = 1'b0;
            idx   = '0;
            for (int j = 0; j < PHYS_REG_SZ; j++) begin
                if (!found && mask[j]) begin
                    found = 1'b1;
                    idx   = IDX_W'(j);
                end
            end
            if (found) begin
                regs_to_use[i*IDX_W +: IDX_W] = idx;
                mask[idx] = 1'b0;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int j = 0; j < PHYS_REG_SZ; j++) begin
            pop = pop + {{IDX_W{1'b0}}, free_q[j]};
        end
        num_regs_available = (pop > (IDX_W+1)'(N)) ? CNT_W'(N) : CNT_W'(pop);
    end

    always_comb begin
        if (restore_valid) begin
            eff_cnt = '0;
        end else if (num_dispatched < num_regs_available) begin
            eff_cnt = num_dispatched;
        end else begin
            eff_cnt = num_regs_available;
        end
        updated_free_list = free_q;
        for (int i = 0; i < N; i++) begin
            if (int'(eff_cnt) > i) begin
                updated_free_list[regs_to_use[i*IDX_W +: IDX_W]] = 1'b0;
            end
        end
    end

    // Duplicate slots naming one register simply OR into the same bit.
    always_comb begin
        retire_set = '0;
        dbl_free   = 1'b0;
        r          = '0;
        for (int i = 0; i < N; i++) begin
            r = retire_reg[i*IDX_W +: IDX_W];
            if (retire_valid[i] && (int'(r) < PHYS_REG_SZ)) begin
                retire_set[r] = 1'b1;
                if (free_q[r]) begin
                    dbl_free = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_q            <= reset_vec();
            double_free_error <= 1'b0;
        end else begin
            free_q            <= (restore_valid ? restore_free_list : updated_free_list) | retire_set;
            double_free_error <= double_free_error | dbl_free;
        end
    end

    assign free_list_copy = free_q;

endmodule
